// File: rtl/tr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tr_gen
//  Purpose  : Periodic TR (transmit/receive) pulse generator. Emits a
//             registered tr pulse of fixed width at a fixed period, plus a
//             two-deep history of tr for downstream edge detection.
//             Supports free-run or sync-armed start, resync to an external
//             frame sync while running, and finite bursts.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous, active-high reset
//             en         - level: 1 = run / arm, 0 = stop at end of period
//             sync_in    - one-cycle external frame sync pulse
//             burst_num  - pulses per run (0 = continuous), sampled at start
//             tr         - TR pulse (registered)
//             tr_edge    - {tr delayed 2, tr delayed 1}; 01 rise, 10 fall
//             tr_cnt     - pulses issued in the current run
//             busy       - 1 while in ARM / HIGH / LOW
//             done       - one-cycle pulse on return to IDLE from HIGH/LOW
//  Revision : 1.0 - initial release
// ============================================================================
module tr_gen #(
   parameter int TR_PERIOD_CLOCK_NUM          = 15000,
   parameter int TR_POSITIVE_PERIOD_CLOCK_NUM = 120,
   parameter int SYNC_MODE                    = 0,
   parameter int RESYNC_EN                    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        sync_in,
   input  logic [15:0] burst_num,
   output logic        tr,
   output logic [1:0]  tr_edge,
   output logic [15:0] tr_cnt,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   // pcnt counts 0..PERIOD-1 across a whole period; HIGH covers 0..WIDTH-1.
   localparam logic [15:0] PCNT_LAST = 16'(TR_PERIOD_CLOCK_NUM - 1);
   localparam logic [15:0] HIGH_LAST = 16'(TR_POSITIVE_PERIOD_CLOCK_NUM - 1);

   state_t      state;
   logic [15:0] pcnt;
   logic [15:0] burst_lat;

   logic burst_met;
   logic period_end;
   logic stop;
   logic resync;

   assign burst_met  = (burst_lat != 16'd0) && (tr_cnt == burst_lat);
   assign period_end = (state == LOW) && (pcnt == PCNT_LAST);
   // Stop has priority over a coincident resync.
   assign stop       = period_end && (!en || burst_met);
   // Once the burst count is reached a resync would issue an extra pulse,
   // so it is ignored and the run finishes at the end of the period.
   assign resync     = (RESYNC_EN != 0) && sync_in && !burst_met &&
                       ((state == HIGH) || (state == LOW));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tr        <= 1'b0;
         tr_edge   <= 2'b00;
         tr_cnt    <= 16'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pcnt      <= 16'd0;
         burst_lat <= 16'd0;
      end else begin
         tr_edge <= {tr_edge[0], tr};
         done    <= 1'b0;

         case (state)
            IDLE: begin
               if (en) begin
                  burst_lat <= burst_num;
                  busy      <= 1'b1;
                  if (SYNC_MODE != 0) begin
                     state  <= ARM;
                     tr_cnt <= 16'd0;
                  end else begin
                     state  <= HIGH;
                     tr     <= 1'b1;
                     pcnt   <= 16'd0;
                     tr_cnt <= 16'd1;
                  end
               end
            end

            ARM: begin
               if (sync_in) begin
                  state  <= HIGH;
                  tr     <= 1'b1;
                  pcnt   <= 16'd0;
                  tr_cnt <= tr_cnt + 16'd1;
               end else if (!en) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            HIGH, LOW: begin
               if (stop) begin
                  state <= IDLE;
                  tr    <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (resync || period_end) begin
                  // Restart the period; if tr is already high it simply
                  // stays high, stretching the pulse without a glitch.
                  state  <= HIGH;
                  tr     <= 1'b1;
                  pcnt   <= 16'd0;
                  tr_cnt <= tr_cnt + 16'd1;
               end else if ((state == HIGH) && (pcnt == HIGH_LAST)) begin
                  state <= LOW;
                  tr    <= 1'b0;
                  pcnt  <= pcnt + 16'd1;
               end else begin
                  pcnt <= pcnt + 16'd1;
               end
            end

            default: begin
               state <= IDLE;
               tr    <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tr_gen
//  Purpose  : Self-checking bench for tr_gen (PERIOD=20, WIDTH=4).
//             dut0 runs free-start mode; dut1 runs sync-armed mode.
//             Expected tr rising edges and done pulses of dut0 are queued
//             when stimulus is issued and consumed by a monitor thread.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tr_gen;

   localparam int PERIOD = 20;
   localparam int WIDTH  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        en = 1'b0, sync_in = 1'b0;
   logic [15:0] burst_num = 16'd0;
   logic        tr, busy, done;
   logic [1:0]  tr_edge;
   logic [15:0] tr_cnt;

   logic        en1 = 1'b0, sync1 = 1'b0;
   logic [15:0] burst1 = 16'd0;
   logic        tr1, busy1, done1;
   logic [1:0]  tr_edge1;
   logic [15:0] tr_cnt1;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int kind;   // 0 = tr rising edge, 1 = done pulse
      int cyc;
      int cnt;
   } exp_t;

   exp_t sb[$];
   logic tr_q = 1'b0;

   tr_gen #(
      .TR_PERIOD_CLOCK_NUM(PERIOD), .TR_POSITIVE_PERIOD_CLOCK_NUM(WIDTH),
      .SYNC_MODE(0), .RESYNC_EN(1)
   ) dut0 (
      .clk(clk), .rst(rst), .en(en), .sync_in(sync_in), .burst_num(burst_num),
      .tr(tr), .tr_edge(tr_edge), .tr_cnt(tr_cnt), .busy(busy), .done(done)
   );

   tr_gen #(
      .TR_PERIOD_CLOCK_NUM(PERIOD), .TR_POSITIVE_PERIOD_CLOCK_NUM(WIDTH),
      .SYNC_MODE(1), .RESYNC_EN(1)
   ) dut1 (
      .clk(clk), .rst(rst), .en(en1), .sync_in(sync1), .burst_num(burst1),
      .tr(tr1), .tr_edge(tr_edge1), .tr_cnt(tr_cnt1), .busy(busy1), .done(done1)
   );

   initial forever #5 clk = ~clk;

   // cyc == k from just after rising edge k until rising edge k+1
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int kind, input int c, input int n);
      sb.push_back('{kind, c, n});
   endtask

   task automatic on_event(input int kind);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s at cycle %0d: tr_cnt=%0d, none expected",
                  (kind == 0) ? "rise" : "done", cyc, tr_cnt);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.cnt != int'(tr_cnt)) begin
            errors++;
            $display("FAIL sb_event: got kind=%0d cycle=%0d cnt=%0d, expected kind=%0d cycle=%0d cnt=%0d",
                     kind, cyc, tr_cnt, e.kind, e.cyc, e.cnt);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      fork
         begin : stim
            wait_to(2);  rst = 1'b0;
            wait_to(3);
            chk("rst_tr", tr, 0);
            chk("rst_tr_edge", tr_edge, 0);
            chk("rst_tr_cnt", tr_cnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);

            // sync while IDLE is ignored by both instances
            wait_to(5);  sync_in = 1'b1; sync1 = 1'b1;
            wait_to(6);  sync_in = 1'b0; sync1 = 1'b0;
            chk("idle_sync_busy0", busy, 0);
            chk("idle_sync_busy1", busy1, 0);

            // free-run continuous start; dut1 arms
            wait_to(10);
            en = 1'b1; burst_num = 16'd0; en1 = 1'b1;
            push(0, 11, 1); push(0, 31, 2); push(0, 51, 3);
            wait_to(11);
            chk("arm_busy1", busy1, 1);
            chk("arm_tr1", tr1, 0);
            wait_to(12); chk("edge_rise_12", tr_edge, 2'b01);
            wait_to(14); chk("tr_high_14", tr, 1);
            wait_to(15); chk("tr_low_15", tr, 0);
            wait_to(16); chk("edge_fall_16", tr_edge, 2'b10);
            wait_to(32); chk("edge_rise_32", tr_edge, 2'b01);

            // sync-armed start
            wait_to(40); chk("armed_tr1_40", tr1, 0); sync1 = 1'b1;
            wait_to(41); sync1 = 1'b0;
            chk("sync_start_tr1", tr1, 1);
            chk("sync_start_cnt1", tr_cnt1, 1);
            wait_to(42); chk("sync_edge1", tr_edge1, 2'b01);
            wait_to(45); en1 = 1'b0;

            // resync in LOW at pcnt=9
            wait_to(60); sync_in = 1'b1;
            push(0, 61, 4); push(0, 81, 5);
            wait_to(61); sync_in = 1'b0;
            chk("done1_61", done1, 1);
            chk("busy1_61", busy1, 0);

            // en dropped at pcnt=2: full pulse, full period, then done
            wait_to(83); en = 1'b0; push(1, 101, 5);
            wait_to(84); chk("stop_tr_84", tr, 1);
            wait_to(85); chk("stop_tr_85", tr, 0);
            wait_to(101);
            chk("stop_busy", busy, 0);
            chk("stop_tr", tr, 0);

            // burst of 3; live burst_num change and late resync ignored
            wait_to(110);
            burst_num = 16'd3; en = 1'b1;
            push(0, 111, 1); push(0, 131, 2); push(0, 151, 3); push(1, 171, 3);
            wait_to(140); burst_num = 16'd2;
            wait_to(160); sync_in = 1'b1;
            wait_to(161); sync_in = 1'b0;
            chk("burst_resync_tr", tr, 0);
            chk("burst_resync_cnt", tr_cnt, 3);
            wait_to(171);
            en = 1'b0; burst_num = 16'd0;
            chk("burst_busy", busy, 0);
            chk("burst_cnt", tr_cnt, 3);

            // async reset mid-pulse
            wait_to(180); en = 1'b1; push(0, 181, 1);
            wait_to(182);
            #2; rst = 1'b1; en = 1'b0;
            #1;
            chk("arst_tr", tr, 0);
            chk("arst_tr_edge", tr_edge, 0);
            chk("arst_tr_cnt", tr_cnt, 0);
            chk("arst_busy", busy, 0);
            wait_to(185); rst = 1'b0;

            // restart after reset
            wait_to(190); en = 1'b1;
            push(0, 191, 1); push(0, 211, 2);
            wait_to(192); chk("restart_edge", tr_edge, 2'b01);
            wait_to(212); en = 1'b0; push(1, 231, 2);

            wait_to(240);
            chk("sb_empty", sb.size(), 0);
         end
         begin : mon
            forever begin
               @(negedge clk);
               if (!rst) begin
                  if (tr && !tr_q) on_event(0);
                  if (done) on_event(1);
               end
               tr_q = tr;
            end
         end
      join_any
      disable fork;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
